// File: rtl/data_mem_responder.sv
// Word-addressed data-memory responder for the MEM stage: fixed-latency IDLE/BUSY/DONE access FSM.
// Optional MISALIGN_CHECK_EN rejects misaligned or simultaneous read+write requests (pulses mem_err).
module data_mem_responder #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memread,
    input  logic              memwrite,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_stall,
    output logic              mem_done,
    output logic              mem_err
);

    if (LAT < 1 || LAT > 15) begin : g_bad_lat
        $error("data_mem_responder: LAT must be in 1..15");
    end

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cnt;
    logic              r_is_wr;
    logic              r_rej;
    logic [ADDR_W-1:0] r_idx;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    logic w_req;
    logic w_rej;
    logic w_accept;
    logic w_commit;
    logic w_unused_addr;

    assign w_req = memread | memwrite;

`ifdef MISALIGN_CHECK_EN
    assign w_rej = (addr[1:0] != 2'b00) | (memread & memwrite);
`else
    assign w_rej = 1'b0;
`endif

    // Upper address bits fall outside the array; the byte offset only matters for the check.
    assign w_unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_next    = r_state;
        mem_stall = 1'b0;
        w_accept  = 1'b0;
        w_commit  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    mem_stall = 1'b1;
                    w_accept  = 1'b1;
                    w_next    = S_BUSY;
                end
            end
            S_BUSY: begin
                mem_stall = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_commit = 1'b1;
                    w_next   = S_DONE;
                end
            end
            // Requests seen here still belong to the completing instruction.
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= 4'd0;
            r_is_wr <= 1'b0;
            r_rej   <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            rdata   <= '0;
        end else begin
            if (w_accept) begin
                r_cnt   <= 4'(LAT - 1);
                r_is_wr <= memwrite;
                r_rej   <= w_rej;
                r_idx   <= addr[ADDR_W+1:2];
                r_wdata <= wdata;
            end else if (r_state == S_BUSY && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit && !r_is_wr && !r_rej) begin
                rdata <= r_mem[r_idx];
            end
        end
    end

    // NOTE: the array has no reset; a reset mid-access forces IDLE, so w_commit drops and
    // the pending write is discarded.
    always_ff @(posedge clk) begin
        if (w_commit && r_is_wr && !r_rej) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign mem_done = (r_state == S_DONE);

`ifdef MISALIGN_CHECK_EN
    assign mem_err = mem_done & r_rej;
`else
    assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a LAT=2 instance for the main sequence and a LAT=1 instance for the wrap case.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd   [2];
    logic        wr   [2];
    logic [31:0] ad   [2];
    logic [31:0] wd   [2];
    logic [31:0] rdat [2];
    logic        stl  [2];
    logic        dn   [2];
    logic        er   [2];

    int vectors = 0;
    int miss    = 0;

`ifdef MISALIGN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(8), .DATA_W(32), .LAT(2)) u_lat2 (
        .clk(clk), .rst(rst), .memread(rd[0]), .memwrite(wr[0]), .addr(ad[0]),
        .wdata(wd[0]), .rdata(rdat[0]), .mem_stall(stl[0]), .mem_done(dn[0]), .mem_err(er[0])
    );

    data_mem_responder #(.ADDR_W(8), .DATA_W(32), .LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .memread(rd[1]), .memwrite(wr[1]), .addr(ad[1]),
        .wdata(wd[1]), .rdata(rdat[1]), .mem_stall(stl[1]), .mem_done(dn[1]), .mem_err(er[1])
    );

    task automatic chk(input string tag, input int u, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s (u%0d): observed %h expected %h", tag, u, obs, exp);
        end
    endtask

    // Starts just after a rising edge with the DUT in IDLE; returns just after the edge leaving DONE.
    task automatic acc(input int u, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic exp_err, input logic [31:0] exp_rd,
                       input logic keep);
        int lat;
        lat   = (u == 0) ? 2 : 1;
        rd[u] = r;
        wr[u] = w;
        ad[u] = a;
        wd[u] = d;
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            chk("stall_high", u, 32'(stl[u]), 32'd1);
            chk("done_early", u, 32'(dn[u]), 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("done_pulse", u, 32'(dn[u]), 32'd1);
        chk("stall_in_done", u, 32'(stl[u]), 32'd0);
        chk("err", u, 32'(er[u]), 32'(exp_err));
        chk("rdata", u, rdat[u], exp_rd);
        @(posedge clk);
        #1;
        if (!keep) begin
            rd[u] = 1'b0;
            wr[u] = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rd[i] = 1'b0;
            wr[i] = 1'b0;
            ad[i] = 32'h0;
            wd[i] = 32'h0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state on both instances.
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_rdata", i, rdat[i], 32'h0);
            chk("rst_stall", i, 32'(stl[i]), 32'd0);
            chk("rst_done", i, 32'(dn[i]), 32'd0);
            chk("rst_err", i, 32'(er[i]), 32'd0);
        end
        @(posedge clk);
        #1;

        // Seed word 0x10, load it so rdata is non-zero before T1.
        acc(0, 1'b0, 1'b1, 32'h10, 32'h1111_1111, 1'b0, 32'h0, 1'b0);
        acc(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h1111_1111, 1'b0);

        // T1: reset in the middle of BUSY of a store.
        wr[0] = 1'b1;
        ad[0] = 32'h10;
        wd[0] = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        #2;
        rst   = 1'b1;
        wr[0] = 1'b0;
        @(negedge clk);
        chk("t1_rdata", 0, rdat[0], 32'h0);
        chk("t1_stall", 0, 32'(stl[0]), 32'd0);
        chk("t1_done", 0, 32'(dn[0]), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        acc(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h1111_1111, 1'b0);

        // T2: store then load at LAT=2.
        acc(0, 1'b0, 1'b1, 32'h04, 32'h1234_5678, 1'b0, 32'h1111_1111, 1'b0);
        acc(0, 1'b1, 1'b0, 32'h04, 32'h0, 1'b0, 32'h1234_5678, 1'b0);

        // T3: memread held through DONE; the next load starts only from IDLE.
        acc(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h1111_1111, 1'b1);
        acc(0, 1'b1, 1'b0, 32'h04, 32'h0, 1'b0, 32'h1234_5678, 1'b0);

        // T5: both requests high (write without the check, rejected with it).
        acc(0, 1'b0, 1'b1, 32'h08, 32'h99, 1'b0, 32'h1234_5678, 1'b0);
        acc(0, 1'b1, 1'b1, 32'h08, 32'h55, CHK, 32'h1234_5678, 1'b0);
        acc(0, 1'b1, 1'b0, 32'h08, 32'h0, 1'b0, CHK ? 32'h99 : 32'h55, 1'b0);

        // T6: misaligned store to 0x06 aliases word 1 unless rejected.
        acc(0, 1'b0, 1'b1, 32'h06, 32'h77, CHK, CHK ? 32'h99 : 32'h55, 1'b0);
        acc(0, 1'b1, 1'b0, 32'h04, 32'h0, 1'b0, CHK ? 32'h1234_5678 : 32'h77, 1'b0);

        // T4: LAT=1, top word, plus an address that wraps onto it.
        acc(1, 1'b0, 1'b1, 32'h3FC, 32'hA5A5_A5A5, 1'b0, 32'h0, 1'b0);
        acc(1, 1'b1, 1'b0, 32'h3FC, 32'h0, 1'b0, 32'hA5A5_A5A5, 1'b0);
        acc(1, 1'b1, 1'b0, 32'h7FC, 32'h0, 1'b0, 32'hA5A5_A5A5, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end

endmodule
